// File: rtl/cfg_width_bridge.sv
// cfg_width_bridge
// Splits one 64-bit-bus configuration request into N = 64/DATA_W narrow beats.
// It issues the beats one at a time and collects one downstream ack per beat.
// When the transaction ends it returns a single upstream ack.
//
// Ports
//   clk, rst_n                  : clock (rising edge), asynchronous active-low reset
//   up_req_*                    : 64-bit request (valid/opcode/addr/be/data/sai/fid)
//   up_ack_*                    : 64-bit ack (read_valid/read_miss/write_valid/write_miss/data)
//   dn_req_*                    : narrow request, be is DATA_W/8 bits and data is DATA_W bits
//   dn_ack_*                    : narrow ack, data is DATA_W bits
//   busy                        : high whenever the FSM is not IDLE
//
// Optional feature: define CFG_WIDTH_BRIDGE_TIMEOUT_EN to enable the WAIT watchdog.
// When it is enabled, a beat with no matching ack TIMEOUT_CYC cycles after its
// dn_req_valid cycle is treated as a miss.
module cfg_width_bridge #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                up_req_valid,
  input  logic [3:0]          up_req_opcode,
  input  logic [47:0]         up_req_addr,
  input  logic [7:0]          up_req_be,
  input  logic [63:0]         up_req_data,
  input  logic [23:0]         up_req_sai,
  input  logic [7:0]          up_req_fid,
  output logic                up_ack_read_valid,
  output logic                up_ack_read_miss,
  output logic                up_ack_write_valid,
  output logic                up_ack_write_miss,
  output logic [63:0]         up_ack_data,
  output logic                dn_req_valid,
  output logic [3:0]          dn_req_opcode,
  output logic [47:0]         dn_req_addr,
  output logic [DATA_W/8-1:0] dn_req_be,
  output logic [DATA_W-1:0]   dn_req_data,
  output logic [23:0]         dn_req_sai,
  output logic [7:0]          dn_req_fid,
  input  logic                dn_ack_read_valid,
  input  logic                dn_ack_read_miss,
  input  logic                dn_ack_write_valid,
  input  logic                dn_ack_write_miss,
  input  logic [DATA_W-1:0]   dn_ack_data,
  output logic                busy
);

  localparam int N    = 64 / DATA_W;
  localparam int BEW  = DATA_W / 8;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // One bit per beat, set when that beat's byte-enable slice is non-zero.
  function automatic logic [N-1:0] beat_mask(input logic [7:0] be);
    for (int i = 0; i < N; i++) begin
      beat_mask[i] = |be[i*BEW +: BEW];
    end
  endfunction

  // Index of the lowest set bit. The caller guarantees that the mask is non-zero.
  function automatic logic [IDXW-1:0] low_idx(input logic [N-1:0] m);
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) begin
        low_idx = i[IDXW-1:0];
      end else begin
        low_idx = low_idx;
      end
    end
  endfunction

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [47:0]         addr_q, addr_d;
  logic [7:0]          be_q, be_d;
  logic [63:0]         data_q, data_d;
  logic [23:0]         sai_q, sai_d;
  logic [7:0]          fid_q, fid_d;
  logic [N-1:0]        pend_q, pend_d;
  logic [IDXW-1:0]     cur_q, cur_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                busy_q, busy_d;
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
  logic [15:0]         cnt_q, cnt_d;
`else
  logic                unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
`endif

  logic                up_rv_q, up_rv_d, up_rm_q, up_rm_d;
  logic                up_wv_q, up_wv_d, up_wm_q, up_wm_d;
  logic [63:0]         up_data_q, up_data_d;
  logic                dn_valid_q, dn_valid_d;
  logic [3:0]          dn_opcode_q, dn_opcode_d;
  logic [47:0]         dn_addr_q, dn_addr_d;
  logic [BEW-1:0]      dn_be_q, dn_be_d;
  logic [DATA_W-1:0]   dn_data_q, dn_data_d;
  logic [23:0]         dn_sai_q, dn_sai_d;
  logic [7:0]          dn_fid_q, dn_fid_d;

  // At acceptance, the first beat is issued straight from the request inputs.
  // This gives first dn_req_valid one cycle after acceptance.
  logic                acc_s;
  logic [3:0]          src_opcode_s;
  logic [47:0]         src_addr_s;
  logic [7:0]          src_be_s;
  logic [63:0]         src_data_s;
  logic [23:0]         src_sai_s;
  logic [7:0]          src_fid_s;
  logic [N-1:0]        iss_mask_s, iss_rest_s;
  logic [IDXW-1:0]     iss_idx_s;
  logic                ack_hit_s, ack_miss_s;

  assign acc_s        = (state_q == IDLE) && up_req_valid;
  assign src_opcode_s = acc_s ? up_req_opcode : opcode_q;
  assign src_addr_s   = acc_s ? up_req_addr : addr_q;
  assign src_be_s     = acc_s ? up_req_be : be_q;
  assign src_data_s   = acc_s ? up_req_data : data_q;
  assign src_sai_s    = acc_s ? up_req_sai : sai_q;
  assign src_fid_s    = acc_s ? up_req_fid : fid_q;
  assign iss_mask_s   = acc_s ? beat_mask(up_req_be) : pend_q;
  assign iss_idx_s    = low_idx(iss_mask_s);

  // Only acks of the transaction's own type count. When valid and miss are both set, it is a miss.
  assign ack_miss_s = is_wr_q ? dn_ack_write_miss : dn_ack_read_miss;
  assign ack_hit_s  = is_wr_q ? (dn_ack_write_valid & ~dn_ack_write_miss)
                              : (dn_ack_read_valid & ~dn_ack_read_miss);

  // Remaining enabled beats after the one that is being issued now.
  always_comb begin
    iss_rest_s = iss_mask_s;
    iss_rest_s[iss_idx_s] = 1'b0;
  end

  // Next-state and registered-output computation for the bridge FSM.
  always_comb begin
    logic do_issue;
    logic do_resp;
    logic resp_miss;
    do_issue    = 1'b0;
    do_resp     = 1'b0;
    resp_miss   = 1'b0;
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    be_d        = be_q;
    data_d      = data_q;
    sai_d       = sai_q;
    fid_d       = fid_q;
    pend_d      = pend_q;
    cur_d       = cur_q;
    rdata_d     = rdata_q;
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    up_rv_d     = 1'b0;
    up_rm_d     = 1'b0;
    up_wv_d     = 1'b0;
    up_wm_d     = 1'b0;
    up_data_d   = 64'd0;
    dn_valid_d  = 1'b0;
    dn_opcode_d = 4'd0;
    dn_addr_d   = 48'd0;
    dn_be_d     = '0;
    dn_data_d   = '0;
    dn_sai_d    = 24'd0;
    dn_fid_d    = 8'd0;

    case (state_q)
      IDLE: begin
        if (up_req_valid) begin
          is_wr_d  = up_req_opcode[0];
          opcode_d = up_req_opcode;
          addr_d   = up_req_addr;
          be_d     = up_req_be;
          data_d   = up_req_data;
          sai_d    = up_req_sai;
          fid_d    = up_req_fid;
          rdata_d  = 64'd0;
          if (up_req_be == 8'h00) begin
            do_resp = 1'b1;
          end else begin
            do_issue = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
        cnt_d   = 16'd1;
`endif
      end
      WAIT: begin
        if (ack_miss_s) begin
          do_resp   = 1'b1;
          resp_miss = 1'b1;
        end else if (ack_hit_s) begin
          if (!is_wr_q) begin
            rdata_d[cur_q*DATA_W +: DATA_W] = dn_ack_data;
          end else begin
            rdata_d = rdata_q;
          end
          if (pend_q != '0) begin
            do_issue = 1'b1;
          end else begin
            do_resp = 1'b1;
          end
        end
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
        // cnt_q equals k in the k-th cycle after the dn_req_valid cycle.
        else if (cnt_q >= 16'(TIMEOUT_CYC)) begin
          do_resp   = 1'b1;
          resp_miss = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_issue) begin
      state_d     = ISSUE;
      pend_d      = iss_rest_s;
      cur_d       = iss_idx_s;
      dn_valid_d  = 1'b1;
      dn_opcode_d = src_opcode_s;
      dn_addr_d   = src_addr_s + (48'(iss_idx_s) * 48'(BEW));
      dn_be_d     = src_be_s[iss_idx_s*BEW +: BEW];
      dn_data_d   = src_data_s[iss_idx_s*DATA_W +: DATA_W];
      dn_sai_d    = src_sai_s;
      dn_fid_d    = src_fid_s;
    end else begin
      dn_valid_d  = 1'b0;
    end

    if (do_resp) begin
      state_d = RESP;
      pend_d  = '0;
      if (is_wr_d) begin
        up_wv_d = ~resp_miss;
        up_wm_d = resp_miss;
      end else begin
        up_rv_d   = ~resp_miss;
        up_rm_d   = resp_miss;
        up_data_d = rdata_d;
      end
    end else begin
      up_data_d = 64'd0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, captured request and registered outputs. All of them clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      opcode_q    <= 4'd0;
      addr_q      <= 48'd0;
      be_q        <= 8'd0;
      data_q      <= 64'd0;
      sai_q       <= 24'd0;
      fid_q       <= 8'd0;
      pend_q      <= '0;
      cur_q       <= '0;
      rdata_q     <= 64'd0;
      busy_q      <= 1'b0;
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
      cnt_q       <= 16'd0;
`endif
      up_rv_q     <= 1'b0;
      up_rm_q     <= 1'b0;
      up_wv_q     <= 1'b0;
      up_wm_q     <= 1'b0;
      up_data_q   <= 64'd0;
      dn_valid_q  <= 1'b0;
      dn_opcode_q <= 4'd0;
      dn_addr_q   <= 48'd0;
      dn_be_q     <= '0;
      dn_data_q   <= '0;
      dn_sai_q    <= 24'd0;
      dn_fid_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      data_q      <= data_d;
      sai_q       <= sai_d;
      fid_q       <= fid_d;
      pend_q      <= pend_d;
      cur_q       <= cur_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
      up_rv_q     <= up_rv_d;
      up_rm_q     <= up_rm_d;
      up_wv_q     <= up_wv_d;
      up_wm_q     <= up_wm_d;
      up_data_q   <= up_data_d;
      dn_valid_q  <= dn_valid_d;
      dn_opcode_q <= dn_opcode_d;
      dn_addr_q   <= dn_addr_d;
      dn_be_q     <= dn_be_d;
      dn_data_q   <= dn_data_d;
      dn_sai_q    <= dn_sai_d;
      dn_fid_q    <= dn_fid_d;
    end
  end

  assign up_ack_read_valid  = up_rv_q;
  assign up_ack_read_miss   = up_rm_q;
  assign up_ack_write_valid = up_wv_q;
  assign up_ack_write_miss  = up_wm_q;
  assign up_ack_data        = up_data_q;
  assign dn_req_valid       = dn_valid_q;
  assign dn_req_opcode      = dn_opcode_q;
  assign dn_req_addr        = dn_addr_q;
  assign dn_req_be          = dn_be_q;
  assign dn_req_data        = dn_data_q;
  assign dn_req_sai         = dn_sai_q;
  assign dn_req_fid         = dn_fid_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_cfg_width_bridge.sv
module tb_cfg_width_bridge;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_req_valid = 1'b0;
  logic [3:0]    up_req_opcode = 4'd0;
  logic [47:0]   up_req_addr = 48'd0;
  logic [7:0]    up_req_be = 8'd0;
  logic [63:0]   up_req_data = 64'd0;
  logic [23:0]   up_req_sai = 24'd0;
  logic [7:0]    up_req_fid = 8'd0;
  logic          up_ack_read_valid, up_ack_read_miss, up_ack_write_valid, up_ack_write_miss;
  logic [63:0]   up_ack_data;
  logic          dn_req_valid;
  logic [3:0]    dn_req_opcode;
  logic [47:0]   dn_req_addr;
  logic [DW/8-1:0] dn_req_be;
  logic [DW-1:0] dn_req_data;
  logic [23:0]   dn_req_sai;
  logic [7:0]    dn_req_fid;
  logic          dn_ack_read_valid = 1'b0;
  logic          dn_ack_read_miss = 1'b0;
  logic          dn_ack_write_valid = 1'b0;
  logic          dn_ack_write_miss = 1'b0;
  logic [DW-1:0] dn_ack_data = '0;
  logic          busy;

  int errors = 0;
  int checks = 0;

  cfg_width_bridge #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(up_req_valid), .up_req_opcode(up_req_opcode), .up_req_addr(up_req_addr),
    .up_req_be(up_req_be), .up_req_data(up_req_data), .up_req_sai(up_req_sai), .up_req_fid(up_req_fid),
    .up_ack_read_valid(up_ack_read_valid), .up_ack_read_miss(up_ack_read_miss),
    .up_ack_write_valid(up_ack_write_valid), .up_ack_write_miss(up_ack_write_miss),
    .up_ack_data(up_ack_data),
    .dn_req_valid(dn_req_valid), .dn_req_opcode(dn_req_opcode), .dn_req_addr(dn_req_addr),
    .dn_req_be(dn_req_be), .dn_req_data(dn_req_data), .dn_req_sai(dn_req_sai), .dn_req_fid(dn_req_fid),
    .dn_ack_read_valid(dn_ack_read_valid), .dn_ack_read_miss(dn_ack_read_miss),
    .dn_ack_write_valid(dn_ack_write_valid), .dn_ack_write_miss(dn_ack_write_miss),
    .dn_ack_data(dn_ack_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [3:0] op, input logic [47:0] a, input logic [7:0] be,
                     input logic [63:0] d);
    up_req_valid  = 1'b1;
    up_req_opcode = op;
    up_req_addr   = a;
    up_req_be     = be;
    up_req_data   = d;
    up_req_sai    = 24'hA5A5A5;
    up_req_fid    = 8'h3C;
  endtask

  task automatic ack(input logic rv, input logic rm, input logic wv, input logic wm,
                     input logic [DW-1:0] d);
    dn_ack_read_valid  = rv;
    dn_ack_read_miss   = rm;
    dn_ack_write_valid = wv;
    dn_ack_write_miss  = wm;
    dn_ack_data        = d;
  endtask

  function automatic logic [3:0] up_acks();
    return {up_ack_read_valid, up_ack_read_miss, up_ack_write_valid, up_ack_write_miss};
  endfunction

  initial begin
    // Reset state
    tick(2);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_dn_valid", {63'd0, dn_req_valid}, 64'd0);
    chk("rst_up_acks", {60'd0, up_acks()}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Two-beat read, addr 0x1000, be 0xFF
    req(4'h0, 48'h1000, 8'hFF, 64'd0);
    tick(1);
    up_req_valid = 1'b0;
    chk("t1_b0_valid", {63'd0, dn_req_valid}, 64'd1);
    chk("t1_b0_addr", {16'd0, dn_req_addr}, 64'h1000);
    chk("t1_b0_be", {60'd0, dn_req_be}, 64'hF);
    chk("t1_b0_sai", {40'd0, dn_req_sai}, 64'hA5A5A5);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    tick(1);
    chk("t1_hold_valid", {63'd0, dn_req_valid}, 64'd0);
    chk("t1_hold_addr", {16'd0, dn_req_addr}, 64'd0);
    ack(1'b1, 1'b0, 1'b0, 1'b0, 32'h11223344);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_b1_valid", {63'd0, dn_req_valid}, 64'd1);
    chk("t1_b1_addr", {16'd0, dn_req_addr}, 64'h1004);
    chk("t1_b1_be", {60'd0, dn_req_be}, 64'hF);
    tick(1);
    ack(1'b1, 1'b0, 1'b0, 1'b0, 32'h55667788);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_up_acks", {60'd0, up_acks()}, 64'b1000);
    chk("t1_up_data", up_ack_data, 64'h5566778811223344);
    tick(1);
    chk("t1_idle_busy", {63'd0, busy}, 64'd0);
    chk("t1_idle_acks", {60'd0, up_acks()}, 64'd0);

    // Write with upper beat only. A wrong-type ack is ignored first.
    req(4'h1, 48'h2000, 8'hF0, 64'hAABBCCDD00000000);
    tick(1);
    up_req_valid = 1'b0;
    chk("t2_valid", {63'd0, dn_req_valid}, 64'd1);
    chk("t2_addr", {16'd0, dn_req_addr}, 64'h2004);
    chk("t2_be", {60'd0, dn_req_be}, 64'hF);
    chk("t2_data", {32'd0, dn_req_data}, 64'hAABBCCDD);
    chk("t2_opcode", {60'd0, dn_req_opcode}, 64'h1);
    tick(1);
    ack(1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678);
    tick(1);
    chk("t2_wrongtype_acks", {60'd0, up_acks()}, 64'd0);
    chk("t2_wrongtype_busy", {63'd0, busy}, 64'd1);
    ack(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t2_up_acks", {60'd0, up_acks()}, 64'b0010);
    chk("t2_up_data", up_ack_data, 64'd0);
    tick(1);

    // Read with all-zero byte enables is answered on the next cycle
    req(4'h0, 48'h3000, 8'h00, 64'd0);
    tick(1);
    up_req_valid = 1'b0;
    chk("t3_dn_valid", {63'd0, dn_req_valid}, 64'd0);
    chk("t3_up_acks", {60'd0, up_acks()}, 64'b1000);
    chk("t3_up_data", up_ack_data, 64'd0);
    tick(1);
    chk("t3_busy", {63'd0, busy}, 64'd0);

    // Read miss on beat 0, with valid and miss both set
    req(4'h0, 48'h4000, 8'hFF, 64'd0);
    tick(1);
    up_req_valid = 1'b0;
    chk("t4_b0_valid", {63'd0, dn_req_valid}, 64'd1);
    tick(1);
    ack(1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t4_up_acks", {60'd0, up_acks()}, 64'b0100);
    chk("t4_up_data", up_ack_data, 64'd0);
    chk("t4_no_beat1", {63'd0, dn_req_valid}, 64'd0);
    tick(1);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_no_beat1_late", {63'd0, dn_req_valid}, 64'd0);

    // Reset while in WAIT. A stray ack afterwards is ignored.
    req(4'h0, 48'h5000, 8'hFF, 64'd0);
    tick(1);
    up_req_valid = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_acks", {60'd0, up_acks()}, 64'd0);
    chk("t5_rst_dn_valid", {63'd0, dn_req_valid}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    ack(1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADBEEF);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    chk("t5_stray_acks", {60'd0, up_acks()}, 64'd0);
    chk("t5_stray_busy", {63'd0, busy}, 64'd0);

    // Normal read after reset. The address wraps at 2^48.
    req(4'h0, 48'hFFFF_FFFF_FFFC, 8'hFF, 64'd0);
    tick(1);
    up_req_valid = 1'b0;
    chk("t6_b0_addr", {16'd0, dn_req_addr}, 64'h0000_FFFF_FFFF_FFFC);
    tick(1);
    ack(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t6_b1_addr", {16'd0, dn_req_addr}, 64'd0);
    tick(1);
    ack(1'b1, 1'b0, 1'b0, 1'b0, 32'h01234567);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t6_up_acks", {60'd0, up_acks()}, 64'b1000);
    chk("t6_up_data", up_ack_data, 64'h01234567DEADBEEF);
    tick(1);

    // Write with no ack
    req(4'h1, 48'h6000, 8'h0F, 64'h0000000011112222);
    tick(1);
    up_req_valid = 1'b0;
    chk("t7_valid", {63'd0, dn_req_valid}, 64'd1);
`ifdef CFG_WIDTH_BRIDGE_TIMEOUT_EN
    tick(16);
    chk("t7_before_to_acks", {60'd0, up_acks()}, 64'd0);
    chk("t7_before_to_busy", {63'd0, busy}, 64'd1);
    tick(1);
    chk("t7_to_acks", {60'd0, up_acks()}, 64'b0001);
    tick(1);
    ack(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick(1);
    ack(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    chk("t7_stray_acks", {60'd0, up_acks()}, 64'd0);
    chk("t7_stray_busy", {63'd0, busy}, 64'd0);
`else
    tick(40);
    chk("t7_wait_acks", {60'd0, up_acks()}, 64'd0);
    chk("t7_wait_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("t7_recover_busy", {63'd0, busy}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
